irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_ctrl_pkg.sv | 14 +
 rtl/irq_controller_if.sv | 24 ++
 rtl/irq_prio_encoder.sv | 19 +
 rtl/irq_controller.sv | 115 +++++++++++
 tb/tb_irq_controller.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared types and default addresses for the interrupt controller
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } irq_state_t;

    localparam int          NSRC_DEF      = 8;
    localparam logic [63:0] MASK_ADDR_DEF = 64'h400;
    localparam logic [63:0] CLR_ADDR_DEF  = 64'h408;

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - data-memory store bus plus request/acknowledge handshake
interface irq_controller_if #(
    parameter int N    = 64,
    parameter int NSRC = 8
);
    localparam int IDW = $clog2(NSRC);

    logic [N-1:0]   DM_addr;
    logic [N-1:0]   DM_writeData;
    logic           DM_writeEnable;
    logic           ExtIAck;
    logic           ExtIRQ;
    logic [IDW-1:0] irq_id;

    modport master (
        output DM_addr, DM_writeData, DM_writeEnable, ExtIAck,
        input  ExtIRQ, irq_id
    );

    modport slave (
        input  DM_addr, DM_writeData, DM_writeEnable, ExtIAck,
        output ExtIRQ, irq_id
    );
endinterface

// File: rtl/irq_prio_encoder.sv
// rtl/irq_prio_encoder.sv - combinational lowest-set-index finder with valid flag
module irq_prio_encoder #(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0]         req,
    output logic [$clog2(NSRC)-1:0] idx,
    output logic                    valid
);
    localparam int IDW = $clog2(NSRC);

    // scan downward so the lowest set index is the last one written
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) idx = IDW'(i);
        end
    end
endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-triggered interrupt controller, optional ack timeout via IRQ_ACK_TIMEOUT_EN
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int           N         = 64,
    parameter int           NSRC      = NSRC_DEF,
    parameter logic [N-1:0] MASK_ADDR = N'(MASK_ADDR_DEF),
    parameter logic [N-1:0] CLR_ADDR  = N'(CLR_ADDR_DEF),
    parameter int           TIMEOUT   = 32
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NSRC-1:0]     irq_src,
    irq_controller_if.slave     bus,
    output logic [NSRC-1:0]     irq_pending,
    output logic [NSRC-1:0]     irq_mask,
    output logic                irq_timeout
);
    localparam int IDW = $clog2(NSRC);

    irq_state_t      state, state_nxt;
    logic [NSRC-1:0] src_prev, pend_q, mask_q;
    logic [NSRC-1:0] rise, clr_mmio, clr_ack;
    logic [IDW-1:0]  id_q, win_idx;
    logic            win_valid, mask_wr, clr_wr, ack_take, timeout_hit;
    logic            unused_wdata;

    assign mask_wr  = bus.DM_writeEnable && (bus.DM_addr == MASK_ADDR);
    assign clr_wr   = bus.DM_writeEnable && (bus.DM_addr == CLR_ADDR);
    assign ack_take = (state == ST_REQ) && bus.ExtIAck;
    assign rise     = irq_src & ~src_prev;
    assign clr_mmio = clr_wr ? bus.DM_writeData[NSRC-1:0] : '0;
    assign clr_ack  = ack_take ? ({{(NSRC-1){1'b0}}, 1'b1} << id_q) : '0;

    assign unused_wdata = ^bus.DM_writeData[N-1:NSRC];

    irq_prio_encoder #(.NSRC(NSRC)) u_prio (
        .req   (pend_q & mask_q),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // source history and pending bits; a fresh rise beats any clear of the same bit
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            src_prev <= '0;
            pend_q   <= '0;
        end else begin
            src_prev <= irq_src;
            pend_q   <= (pend_q & ~(clr_mmio | clr_ack)) | rise;
        end
    end

    // mask register loaded by a store to the mask address
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)       mask_q <= '0;
        else if (mask_wr) mask_q <= bus.DM_writeData[NSRC-1:0];
    end

`ifdef IRQ_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_flag;

    assign timeout_hit = (state == ST_REQ) && !bus.ExtIAck && (tmo_cnt == TW'(TIMEOUT - 1));
    assign irq_timeout = tmo_flag;

    // counts unacknowledged cycles spent requesting; idle outside REQ
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)                                                 tmo_cnt <= '0;
        else if (state == ST_REQ && !bus.ExtIAck && !timeout_hit)   tmo_cnt <= tmo_cnt + 1'b1;
        else                                                        tmo_cnt <= '0;
    end

    // sticky timeout flag; a new timeout wins over a simultaneous clear store
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)           tmo_flag <= 1'b0;
        else if (timeout_hit) tmo_flag <= 1'b1;
        else if (clr_wr)      tmo_flag <= 1'b0;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign timeout_hit        = 1'b0;
    assign irq_timeout        = 1'b0;
`endif

    // state register
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next-state: pick up eligible work when idle, leave REQ on ack or timeout
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (win_valid) state_nxt = ST_REQ;
            ST_REQ:  if (bus.ExtIAck || timeout_hit) state_nxt = ST_HOLD;
            ST_HOLD: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // winner is frozen on the IDLE->REQ edge so it cannot change mid-request
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)                          id_q <= '0;
        else if (state == ST_IDLE && win_valid) id_q <= win_idx;
    end

    assign bus.ExtIRQ = (state == ST_REQ);
    assign bus.irq_id = id_q;
    assign irq_pending = pend_q;
    assign irq_mask    = mask_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller
module tb_irq_controller;
    localparam logic [63:0] MASK_A = 64'h400;
    localparam logic [63:0] CLR_A  = 64'h408;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_src;
    logic [7:0] irq_pending, irq_mask;
    logic       irq_timeout;
    int         passed = 0;
    int         total  = 0;

    irq_controller_if #(.N(64), .NSRC(8)) bus ();

    irq_controller #(
        .N(64), .NSRC(8), .MASK_ADDR(MASK_A), .CLR_ADDR(CLR_A), .TIMEOUT(32)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (rst_n),
        .irq_src     (irq_src),
        .bus         (bus),
        .irq_pending (irq_pending),
        .irq_mask    (irq_mask),
        .irq_timeout (irq_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        irq_src            = '0;
        bus.DM_addr        = '0;
        bus.DM_writeData   = '0;
        bus.DM_writeEnable = 1'b0;
        bus.ExtIAck        = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    task automatic mmio(input logic [63:0] a, input logic [63:0] d);
        bus.DM_addr = a; bus.DM_writeData = d; bus.DM_writeEnable = 1'b1;
        cycle();
        bus.DM_writeEnable = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.ExtIAck = 1'b1;
        cycle();
        bus.ExtIAck = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) cycle();
        total++; if (bus.ExtIRQ !== 1'b0) $display("FAIL rst_irq: got %b want 0", bus.ExtIRQ); else passed++;
        total++; if (bus.irq_id !== 3'd0) $display("FAIL rst_id: got %0d want 0", bus.irq_id); else passed++;
        total++; if (irq_pending !== 8'h00) $display("FAIL rst_pend: got %h want 00", irq_pending); else passed++;
        total++; if (irq_mask !== 8'h00) $display("FAIL rst_mask: got %h want 00", irq_mask); else passed++;
        total++; if (irq_timeout !== 1'b0) $display("FAIL rst_tmo: got %b want 0", irq_timeout); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        mmio(MASK_A, 64'h01);
        total++; if (irq_mask !== 8'h01) $display("FAIL basic_mask: got %h want 01", irq_mask); else passed++;
        irq_src = 8'h01;
        cycle();
        total++; if (irq_pending !== 8'h01) $display("FAIL basic_pend: got %h want 01", irq_pending); else passed++;
        total++; if (bus.ExtIRQ !== 1'b0) $display("FAIL basic_early: got %b want 0", bus.ExtIRQ); else passed++;
        irq_src = 8'h00;
        cycle();
        total++; if (bus.ExtIRQ !== 1'b1) $display("FAIL basic_irq: got %b want 1", bus.ExtIRQ); else passed++;
        total++; if (bus.irq_id !== 3'd0) $display("FAIL basic_id: got %0d want 0", bus.irq_id); else passed++;
        ack_pulse();
        total++; if (irq_pending !== 8'h00) $display("FAIL basic_ackclr: got %h want 00", irq_pending); else passed++;
        total++; if (bus.ExtIRQ !== 1'b0) $display("FAIL basic_hold: got %b want 0", bus.ExtIRQ); else passed++;
        repeat (2) cycle();
        total++; if (bus.ExtIRQ !== 1'b0) $display("FAIL basic_idle: got %b want 0", bus.ExtIRQ); else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        mmio(MASK_A, 64'hFF);
        irq_src = 8'h24;
        cycle();
        irq_src = 8'h00;
        cycle();
        total++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 3'd2)
            $display("FAIL prio_first: got irq=%b id=%0d want irq=1 id=2", bus.ExtIRQ, bus.irq_id); else passed++;
        ack_pulse();
        total++; if (irq_pending !== 8'h20) $display("FAIL prio_pend: got %h want 20", irq_pending); else passed++;
        total++; if (bus.ExtIRQ !== 1'b0) $display("FAIL prio_hold: got %b want 0", bus.ExtIRQ); else passed++;
        repeat (2) cycle();
        total++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 3'd5)
            $display("FAIL prio_second: got irq=%b id=%0d want irq=1 id=5", bus.ExtIRQ, bus.irq_id); else passed++;
        ack_pulse();
    endtask

    task automatic test_mask_gate();
        do_reset();
        irq_src = 8'h08;
        cycle();
        irq_src = 8'h00;
        repeat (2) cycle();
        total++; if (irq_pending !== 8'h08) $display("FAIL gate_pend: got %h want 08", irq_pending); else passed++;
        total++; if (bus.ExtIRQ !== 1'b0) $display("FAIL gate_masked: got %b want 0", bus.ExtIRQ); else passed++;
        ack_pulse();
        total++; if (irq_pending !== 8'h08) $display("FAIL gate_stray_ack: got %h want 08", irq_pending); else passed++;
        mmio(MASK_A, 64'h08);
        cycle();
        total++; if (bus.ExtIRQ !== 1'b1 || bus.irq_id !== 3'd3)
            $display("FAIL gate_unmask: got irq=%b id=%0d want irq=1 id=3", bus.ExtIRQ, bus.irq_id); else passed++;
        mmio(MASK_A, 64'h00);
        mmio(CLR_A, 64'h08);
        total++; if (bus.ExtIRQ !== 1'b1) $display("FAIL gate_no_retract: got %b want 1", bus.ExtIRQ); else passed++;
        total++; if (irq_pending !== 8'h00) $display("FAIL gate_clr_in_req: got %h want 00", irq_pending); else passed++;
        ack_pulse();
        total++; if (bus.ExtIRQ !== 1'b0) $display("FAIL gate_after_ack: got %b want 0", bus.ExtIRQ); else passed++;
    endtask

    task automatic test_set_wins();
        do_reset();
        irq_src = 8'h02;
        cycle();
        irq_src = 8'h00;
        cycle();
        total++; if (irq_pending !== 8'h02) $display("FAIL setwin_pre: got %h want 02", irq_pending); else passed++;
        irq_src = 8'h02;
        mmio(CLR_A, 64'h02);
        total++; if (irq_pending !== 8'h02) $display("FAIL setwin_same_cycle: got %h want 02", irq_pending); else passed++;
        mmio(CLR_A, 64'h02);
        total++; if (irq_pending !== 8'h00) $display("FAIL setwin_level_clr: got %h want 00", irq_pending); else passed++;
        irq_src = 8'h00;
    endtask

    task automatic test_random();
        logic [7:0]  m_pend, m_mask, m_prev, nxt, elig, src, dat;
        logic        m_req, m_hold, we, ack;
        logic [63:0] addr;
        int          m_id, req_len;
        do_reset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_req = 1'b0; m_hold = 1'b0; m_id = 0; req_len = 0;
        for (int c = 0; c < 400; c++) begin
            src = 8'($urandom & $urandom & $urandom);
            we  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       addr = MASK_A;
                1:       addr = CLR_A;
                default: addr = 64'h410;
            endcase
            bus.DM_writeData = {$urandom, $urandom};
            dat = bus.DM_writeData[7:0];
            ack = ($urandom_range(0, 2) == 0) || (m_req && req_len >= 20);
            irq_src = src; bus.DM_addr = addr; bus.DM_writeEnable = we; bus.ExtIAck = ack;
            nxt = m_pend;
            if (we && addr == CLR_A) nxt = nxt & ~dat;
            if (m_req && ack) nxt[m_id] = 1'b0;
            nxt = nxt | (src & ~m_prev);
            if (m_hold) m_hold = 1'b0;
            else if (m_req) begin
                req_len++;
                if (ack) begin m_req = 1'b0; m_hold = 1'b1; end
            end else begin
                elig = m_pend & m_mask;
                if (elig != 0) begin
                    m_req = 1'b1; req_len = 0;
                    m_id = $clog2(elig & (~elig + 8'd1));
                end
            end
            if (we && addr == MASK_A) m_mask = dat;
            m_prev = src;
            m_pend = nxt;
            cycle();
            total++; if (bus.ExtIRQ !== m_req) $display("FAIL rnd_irq c=%0d: got %b want %b", c, bus.ExtIRQ, m_req); else passed++;
            if (m_req) begin
                total++; if (bus.irq_id !== 3'(m_id)) $display("FAIL rnd_id c=%0d: got %0d want %0d", c, bus.irq_id, m_id); else passed++;
            end
            total++; if (irq_pending !== m_pend) $display("FAIL rnd_pend c=%0d: got %h want %h", c, irq_pending, m_pend); else passed++;
            total++; if (irq_mask !== m_mask) $display("FAIL rnd_mask c=%0d: got %h want %h", c, irq_mask, m_mask); else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        mmio(MASK_A, 64'h01);
        irq_src = 8'h01;
        cycle();
        irq_src = 8'h00;
        cycle();
        total++; if (bus.ExtIRQ !== 1'b1) $display("FAIL midrst_pre: got %b want 1", bus.ExtIRQ); else passed++;
        rst_n = 1'b0;
        #2;
        total++; if (bus.ExtIRQ !== 1'b0) $display("FAIL midrst_irq: got %b want 0", bus.ExtIRQ); else passed++;
        total++; if (irq_pending !== 8'h00) $display("FAIL midrst_pend: got %h want 00", irq_pending); else passed++;
        total++; if (irq_mask !== 8'h00) $display("FAIL midrst_mask: got %h want 00", irq_mask); else passed++;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        int hi;
        do_reset();
        mmio(MASK_A, 64'h01);
        irq_src = 8'h01;
        cycle();
        irq_src = 8'h00;
        cycle();
`ifdef IRQ_ACK_TIMEOUT_EN
        hi = 0;
        for (int k = 0; k < 100 && bus.ExtIRQ === 1'b1; k++) begin
            hi++;
            cycle();
        end
        total++; if (hi != 32) $display("FAIL tmo_len: got %0d want 32", hi); else passed++;
        total++; if (irq_timeout !== 1'b1) $display("FAIL tmo_flag: got %b want 1", irq_timeout); else passed++;
        total++; if (irq_pending !== 8'h01) $display("FAIL tmo_pend_kept: got %h want 01", irq_pending); else passed++;
        repeat (2) cycle();
        total++; if (bus.ExtIRQ !== 1'b1) $display("FAIL tmo_reissue: got %b want 1", bus.ExtIRQ); else passed++;
        mmio(CLR_A, 64'h01);
        total++; if (irq_timeout !== 1'b0) $display("FAIL tmo_clr: got %b want 0", irq_timeout); else passed++;
`else
        hi = 0;
        repeat (40) cycle();
        total++; if (bus.ExtIRQ !== 1'b1) $display("FAIL notmo_wait: got %b want 1", bus.ExtIRQ); else passed++;
        total++; if (irq_timeout !== 1'b0) $display("FAIL notmo_flag: got %b want 0", irq_timeout); else passed++;
`endif
        ack_pulse();
        repeat (2) cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_priority();
        test_mask_gate();
        test_set_wins();
        test_random();
        test_reset_mid_req();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
